// File: rtl/user_ddr_strm_generator.sv
// Bridges a user write stream and read stream onto a DDR arbiter slave port.
// Writes go through a single-beat request register; reads use credits sized to a return FIFO.
module user_ddr_strm_generator #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 256,
   parameter int BE_WIDTH   = 32,
   parameter int RD_DEPTH   = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_start,
   input  logic [ADDR_WIDTH-1:0] i_wr_base_addr,
   input  logic [31:0]           i_wr_len,
   output logic                  o_wr_done,
   input  logic                  i_rd_start,
   input  logic [ADDR_WIDTH-1:0] i_rd_base_addr,
   input  logic [31:0]           i_rd_len,
   output logic                  o_rd_done,
   input  logic                  i_wr_tvalid,
   output logic                  o_wr_tready,
   input  logic [DATA_WIDTH-1:0] i_wr_tdata,
   output logic                  o_rd_tvalid,
   input  logic                  i_rd_tready,
   output logic [DATA_WIDTH-1:0] o_rd_tdata,
   output logic                  o_ddr_wr_req,
   input  logic                  i_ddr_wr_ack,
   output logic [ADDR_WIDTH-1:0] o_ddr_wr_addr,
   output logic [DATA_WIDTH-1:0] o_ddr_wr_data,
   output logic [BE_WIDTH-1:0]   o_ddr_wr_be_n,
   output logic                  o_ddr_rd_req,
   input  logic                  i_ddr_rd_ack,
   output logic [ADDR_WIDTH-1:0] o_ddr_rd_addr,
   input  logic [DATA_WIDTH-1:0] i_ddr_rd_data,
   input  logic                  i_ddr_rd_data_valid
);
   localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
   localparam int PW = $clog2(RD_DEPTH);
   localparam int CW = $clog2(RD_DEPTH) + 1;

   typedef enum logic {WR_IDLE, WR_BUSY} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_DRAIN} rd_state_t;

   wr_state_t             wr_state, wr_state_nxt;
   logic [ADDR_WIDTH-1:0] wr_addr, wr_req_addr;
   logic [DATA_WIDTH-1:0] wr_req_data;
   logic [31:0]           wr_left;
   logic                  wr_full, wr_done, wr_ready, wr_accept, wr_hs, wr_last_hs;

   // wr_left counts beats still to be taken from the user, so an empty count
   // with a full register means the register holds the final beat.
   assign wr_hs      = wr_full && i_ddr_wr_ack;
   assign wr_last_hs = wr_hs && (wr_left == 32'd0);
   assign wr_accept  = i_wr_tvalid && wr_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) wr_state <= WR_IDLE;
      else          wr_state <= wr_state_nxt;
   end

   always_comb begin
      wr_state_nxt = wr_state;
      wr_ready     = 1'b0;
      case (wr_state)
         WR_IDLE: if (i_wr_start && i_wr_len != 32'd0) wr_state_nxt = WR_BUSY;
         WR_BUSY: begin
            wr_ready = (wr_left != 32'd0) && (!wr_full || i_ddr_wr_ack);
            if (wr_last_hs) wr_state_nxt = WR_IDLE;
         end
         default: wr_state_nxt = WR_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_addr     <= '0;
         wr_req_addr <= '0;
         wr_req_data <= '0;
         wr_left     <= '0;
         wr_full     <= 1'b0;
         wr_done     <= 1'b0;
      end else begin
         wr_done <= (wr_state == WR_IDLE && i_wr_start && i_wr_len == 32'd0) || wr_last_hs;
         if (wr_state == WR_IDLE && i_wr_start) begin
            wr_addr <= i_wr_base_addr;
            wr_left <= i_wr_len;
         end
         if (wr_accept) begin
            wr_full     <= 1'b1;
            wr_req_addr <= wr_addr;
            wr_req_data <= i_wr_tdata;
            wr_addr     <= wr_addr + BEAT_BYTES;
            wr_left     <= wr_left - 32'd1;
         end else if (wr_hs) begin
            wr_full <= 1'b0;
         end
      end
   end

   assign o_wr_tready   = wr_ready;
   assign o_wr_done     = wr_done;
   assign o_ddr_wr_req  = wr_full;
   assign o_ddr_wr_addr = wr_req_addr;
   assign o_ddr_wr_data = wr_req_data;
   assign o_ddr_wr_be_n = '0;

   rd_state_t             rd_state, rd_state_nxt;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [31:0]           rd_req_left, rd_beats_left;
   logic [CW-1:0]         rd_outst, fifo_cnt;
   logic [CW:0]           rd_credit_used;
   logic [PW-1:0]         wptr, rptr;
   logic [DATA_WIDTH-1:0] fifo_mem [RD_DEPTH];
   logic                  rd_req, rd_ack_hs, rd_push, rd_pop, rd_last_pop, rd_done;

   // Data is only accepted against an outstanding credit, which drops returns
   // belonging to a transfer abandoned by reset.
   assign rd_credit_used = {1'b0, rd_outst} + {1'b0, fifo_cnt};
   assign rd_ack_hs      = rd_req && i_ddr_rd_ack;
   assign rd_push        = i_ddr_rd_data_valid && (rd_outst != '0);
   assign rd_pop         = (fifo_cnt != '0) && i_rd_tready;
   assign rd_last_pop    = rd_pop && (rd_state == RD_DRAIN) && (rd_beats_left == 32'd1);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) rd_state <= RD_IDLE;
      else          rd_state <= rd_state_nxt;
   end

   always_comb begin
      rd_state_nxt = rd_state;
      rd_req       = 1'b0;
      case (rd_state)
         RD_IDLE: if (i_rd_start && i_rd_len != 32'd0) rd_state_nxt = RD_REQ;
         RD_REQ: begin
            rd_req = rd_credit_used < (CW+1)'(RD_DEPTH);
            if (rd_ack_hs && rd_req_left == 32'd1) rd_state_nxt = RD_DRAIN;
         end
         RD_DRAIN: if (rd_last_pop) rd_state_nxt = RD_IDLE;
         default:  rd_state_nxt = RD_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rd_addr       <= '0;
         rd_req_left   <= '0;
         rd_beats_left <= '0;
         rd_outst      <= '0;
         fifo_cnt      <= '0;
         wptr          <= '0;
         rptr          <= '0;
         rd_done       <= 1'b0;
      end else begin
         rd_done <= (rd_state == RD_IDLE && i_rd_start && i_rd_len == 32'd0) || rd_last_pop;
         if (rd_state == RD_IDLE && i_rd_start) begin
            rd_addr       <= i_rd_base_addr;
            rd_req_left   <= i_rd_len;
            rd_beats_left <= i_rd_len;
         end
         if (rd_ack_hs) begin
            rd_addr     <= rd_addr + BEAT_BYTES;
            rd_req_left <= rd_req_left - 32'd1;
         end
         case ({rd_ack_hs, rd_push})
            2'b10:   rd_outst <= rd_outst + CW'(1);
            2'b01:   rd_outst <= rd_outst - CW'(1);
            default: ;
         endcase
         if (rd_push) wptr <= wptr + PW'(1);
         if (rd_pop) begin
            rptr          <= rptr + PW'(1);
            rd_beats_left <= rd_beats_left - 32'd1;
         end
         case ({rd_push, rd_pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (rd_push) fifo_mem[wptr] <= i_ddr_rd_data;
   end

   assign o_rd_tvalid   = (fifo_cnt != '0);
   assign o_rd_tdata    = (fifo_cnt != '0) ? fifo_mem[rptr] : '0;
   assign o_rd_done     = rd_done;
   assign o_ddr_rd_req  = rd_req;
   assign o_ddr_rd_addr = rd_addr;
endmodule

// File: tb/tb_user_ddr_strm_generator.sv
// Scoreboard bench: stimulus queues expected DDR beats and read data, negedge monitors check them.
module tb_user_ddr_strm_generator;
   localparam int AW = 32, DW = 256, BW = 32, RD = 8;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          wr_start, rd_start, wr_done, rd_done;
   logic [AW-1:0] wr_base, rd_base;
   logic [31:0]   wr_len, rd_len;
   logic          wr_tvalid, wr_tready, rd_tvalid, rd_tready;
   logic [DW-1:0] wr_tdata, rd_tdata;
   logic          ddr_wr_req, ddr_wr_ack, ddr_rd_req, ddr_rd_ack, ddr_rd_valid;
   logic [AW-1:0] ddr_wr_addr, ddr_rd_addr;
   logic [DW-1:0] ddr_wr_data, ddr_rd_data;
   logic [BW-1:0] ddr_wr_be_n;

   always #5 clk = ~clk;

   user_ddr_strm_generator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .RD_DEPTH(RD)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wr_start(wr_start), .i_wr_base_addr(wr_base), .i_wr_len(wr_len), .o_wr_done(wr_done),
      .i_rd_start(rd_start), .i_rd_base_addr(rd_base), .i_rd_len(rd_len), .o_rd_done(rd_done),
      .i_wr_tvalid(wr_tvalid), .o_wr_tready(wr_tready), .i_wr_tdata(wr_tdata),
      .o_rd_tvalid(rd_tvalid), .i_rd_tready(rd_tready), .o_rd_tdata(rd_tdata),
      .o_ddr_wr_req(ddr_wr_req), .i_ddr_wr_ack(ddr_wr_ack), .o_ddr_wr_addr(ddr_wr_addr),
      .o_ddr_wr_data(ddr_wr_data), .o_ddr_wr_be_n(ddr_wr_be_n),
      .o_ddr_rd_req(ddr_rd_req), .i_ddr_rd_ack(ddr_rd_ack), .o_ddr_rd_addr(ddr_rd_addr),
      .i_ddr_rd_data(ddr_rd_data), .i_ddr_rd_data_valid(ddr_rd_valid)
   );

   typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wbeat_t;
   typedef struct {logic [AW-1:0] addr; int due;} pend_t;

   wbeat_t        wr_exp_q[$];
   logic [AW-1:0] rd_addr_exp_q[$];
   logic [DW-1:0] rd_data_exp_q[$];
   pend_t         pend_q[$];

   int checks = 0, failures = 0;
   int cyc = 0, rd_lat = 2, rd_ack_cnt = 0, wr_done_cnt = 0, rd_done_cnt = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
      return {8{a ^ 32'hA5A5_0000}};
   endfunction

   function automatic logic [DW-1:0] wdat(input int i);
      return {8{32'(32'hD000_0000 + i)}};
   endfunction

   // Monitors: every DDR handshake and every user read beat is checked against the queues.
   always @(negedge clk) begin : mon_wr
      wbeat_t e;
      if (wr_done) wr_done_cnt++;
      if (ddr_wr_req && ddr_wr_ack) begin
         if (wr_exp_q.size() == 0) fail_now("wr_unexpected_beat");
         else begin
            e = wr_exp_q.pop_front();
            chk("wr_addr", DW'(ddr_wr_addr), DW'(e.addr));
            chk("wr_data", ddr_wr_data, e.data);
            chk("wr_be_n", DW'(ddr_wr_be_n), '0);
         end
      end
   end

   always @(negedge clk) begin : mon_rd
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      if (rd_done) rd_done_cnt++;
      if (ddr_rd_req && ddr_rd_ack) begin
         rd_ack_cnt++;
         pend_q.push_back('{ddr_rd_addr, cyc + rd_lat});
         if (rd_addr_exp_q.size() == 0) fail_now("rd_unexpected_req");
         else begin
            ea = rd_addr_exp_q.pop_front();
            chk("rd_addr", DW'(ddr_rd_addr), DW'(ea));
         end
      end
      if (rd_tvalid && rd_tready) begin
         if (rd_data_exp_q.size() == 0) fail_now("rd_unexpected_beat");
         else begin
            ed = rd_data_exp_q.pop_front();
            chk("rd_data", rd_tdata, ed);
         end
      end
   end

   // DDR read responder: returns each acked address after rd_lat cycles, in order.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
         ddr_rd_valid = 1'b1;
         ddr_rd_data  = mem_data(pend_q[0].addr);
         void'(pend_q.pop_front());
      end else begin
         ddr_rd_valid = 1'b0;
         ddr_rd_data  = '0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_wr_req"}, DW'(ddr_wr_req), '0);
      chk({tag, "_rd_req"}, DW'(ddr_rd_req), '0);
      chk({tag, "_wr_tready"}, DW'(wr_tready), '0);
      chk({tag, "_rd_tvalid"}, DW'(rd_tvalid), '0);
      chk({tag, "_wr_done"}, DW'(wr_done), '0);
      chk({tag, "_rd_done"}, DW'(rd_done), '0);
      chk({tag, "_wr_addr"}, DW'(ddr_wr_addr), '0);
      chk({tag, "_wr_data"}, ddr_wr_data, '0);
      chk({tag, "_rd_addr"}, DW'(ddr_rd_addr), '0);
      chk({tag, "_rd_tdata"}, rd_tdata, '0);
   endtask

   task automatic start_wr(input logic [AW-1:0] base, input int len);
      wr_start = 1'b1; wr_base = base; wr_len = 32'(len);
      tick();
      wr_start = 1'b0;
   endtask

   task automatic start_rd(input logic [AW-1:0] base, input int len);
      rd_start = 1'b1; rd_base = base; rd_len = 32'(len);
      tick();
      rd_start = 1'b0;
   endtask

   task automatic send_wr(input logic [DW-1:0] d);
      bit ok;
      ok = 1'b0;
      wr_tvalid = 1'b1; wr_tdata = d;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (wr_tready) ok = 1'b1;
      end
      if (!ok) fail_now("wr_tready_timeout");
      tick();
      wr_tvalid = 1'b0;
   endtask

   task automatic wait_wr_done(input int target, input int budget);
      for (int i = 0; i < budget && wr_done_cnt < target; i++) tick();
      chk("wr_done_count", DW'(wr_done_cnt), DW'(target));
   endtask

   task automatic wait_rd_done(input int target, input int budget);
      for (int i = 0; i < budget && rd_done_cnt < target; i++) tick();
      chk("rd_done_count", DW'(rd_done_cnt), DW'(target));
   endtask

   initial begin
      int base_ack, vcount;
      wr_start = 0; rd_start = 0; wr_base = '0; rd_base = '0; wr_len = '0; rd_len = '0;
      wr_tvalid = 0; wr_tdata = '0; rd_tready = 0; ddr_wr_ack = 0; ddr_rd_ack = 0;
      ddr_rd_valid = 0; ddr_rd_data = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // zero-length on both sides
      wr_start = 1; rd_start = 1; wr_len = 0; rd_len = 0; wr_base = 32'h40; rd_base = 32'h80;
      tick();
      wr_start = 0; rd_start = 0;
      @(negedge clk);
      chk("zl_wr_done", DW'(wr_done), DW'(1));
      chk("zl_rd_done", DW'(rd_done), DW'(1));
      chk("zl_wr_req", DW'(ddr_wr_req), '0);
      chk("zl_rd_req", DW'(ddr_rd_req), '0);
      tick();
      @(negedge clk);
      chk("zl_wr_done_drop", DW'(wr_done), '0);
      chk("zl_rd_done_drop", DW'(rd_done), '0);
      chk("zl_wr_req_after", DW'(ddr_wr_req), '0);
      tick();

      // 4-beat write, ack every cycle
      ddr_wr_ack = 1;
      for (int i = 0; i < 4; i++) wr_exp_q.push_back('{32'h100 + 32'(32 * i), wdat(i)});
      start_wr(32'h100, 4);
      for (int i = 0; i < 4; i++) send_wr(wdat(i));
      wait_wr_done(2, 20);
      repeat (5) tick();
      chk("wr4_single_done", DW'(wr_done_cnt), DW'(2));
      chk("wr4_queue_empty", DW'(wr_exp_q.size()), '0);

      // write held off by ack low for 5 cycles
      ddr_wr_ack = 0;
      wr_exp_q.push_back('{32'h200, wdat(10)});
      wr_exp_q.push_back('{32'h220, wdat(11)});
      start_wr(32'h200, 2);
      send_wr(wdat(10));
      wr_tvalid = 1; wr_tdata = wdat(11);
      repeat (5) begin
         @(negedge clk);
         chk("stall_wr_req", DW'(ddr_wr_req), DW'(1));
         chk("stall_wr_addr", DW'(ddr_wr_addr), DW'(32'h200));
         chk("stall_wr_data", ddr_wr_data, wdat(10));
         chk("stall_wr_tready", DW'(wr_tready), '0);
      end
      tick();
      ddr_wr_ack = 1;
      send_wr(wdat(11));
      wait_wr_done(3, 20);
      chk("stall_queue_empty", DW'(wr_exp_q.size()), '0);

      // 3-beat read, data 10 cycles after ack
      rd_lat = 10; rd_tready = 1; ddr_rd_ack = 1;
      for (int i = 0; i < 3; i++) begin
         rd_addr_exp_q.push_back(32'h400 + 32'(32 * i));
         rd_data_exp_q.push_back(mem_data(32'h400 + 32'(32 * i)));
      end
      start_rd(32'h400, 3);
      wait_rd_done(2, 200);
      chk("rd3_data_q_empty", DW'(rd_data_exp_q.size()), '0);

      // 20-beat read with sink stalled: credits cap at RD_DEPTH
      rd_lat = 2; rd_tready = 0;
      for (int i = 0; i < 20; i++) begin
         rd_addr_exp_q.push_back(32'(32 * i));
         rd_data_exp_q.push_back(mem_data(32'(32 * i)));
      end
      base_ack = rd_ack_cnt;
      start_rd(32'h0, 20);
      repeat (40) tick();
      @(negedge clk);
      chk("rd20_acks_capped", DW'(rd_ack_cnt - base_ack), DW'(8));
      chk("rd20_req_low", DW'(ddr_rd_req), '0);
      chk("rd20_tvalid", DW'(rd_tvalid), DW'(1));
      tick();
      rd_tready = 1;
      wait_rd_done(3, 400);
      chk("rd20_total_acks", DW'(rd_ack_cnt - base_ack), DW'(20));
      chk("rd20_data_q_empty", DW'(rd_data_exp_q.size()), '0);

      // reset mid-read with 2 outstanding
      rd_lat = 10;
      rd_addr_exp_q.push_back(32'h800);
      rd_addr_exp_q.push_back(32'h820);
      base_ack = rd_ack_cnt;
      start_rd(32'h800, 4);
      for (int i = 0; i < 50 && (rd_ack_cnt - base_ack) < 2; i++) begin
         @(negedge clk);
         #1;
      end
      tick();
      ddr_rd_ack = 0;
      chk("mid_acks", DW'(rd_ack_cnt - base_ack), DW'(2));
      rst_n = 0;
      repeat (2) tick();
      @(negedge clk);
      check_idle("mid_rst");
      tick();
      rst_n = 1;
      ddr_rd_ack = 1;
      vcount = 0;
      repeat (30) begin
         @(negedge clk);
         if (rd_tvalid || ddr_rd_req) vcount++;
      end
      chk("late_data_ignored", DW'(vcount), '0);
      chk("no_done_after_rst", DW'(rd_done_cnt), DW'(3));
      chk("late_data_returned", DW'(pend_q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
